// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing bundle for the hazard/stall controller: hazard sources,
// data-cache handshake and the per-register advance/bubble controls.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_is_halt;
    logic [4:0]       idex_rd;
    logic             idex_mem_read;
    logic             ex_mispredict;
    logic             exmem_mem_req;
    logic             dcache_ready;
    logic             dcache_valid;
    logic             dcache_hit;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_write;
    logic             memwb_bubble;
    logic             is_halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_halt,
        input  idex_rd, idex_mem_read, ex_mispredict,
        input  exmem_mem_req, dcache_ready, dcache_valid, dcache_hit,
        output pc_write, ifid_write, ifid_flush, idex_write,
        output idex_bubble, exmem_write, memwb_bubble, is_halted,
        output stall_cycles, flush_count
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_halt,
        output idex_rd, idex_mem_read, ex_mispredict,
        output exmem_mem_req, dcache_ready, dcache_valid, dcache_hit,
        input  pc_write, ifid_write, ifid_flush, idex_write,
        input  idex_bubble, exmem_write, memwb_bubble, is_halted,
        input  stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use stalls, mispredict flushes, d-cache miss
// stalls and the ECALL drain-then-halt sequence, plus perf counters.
module hazard_stall_ctrl #(
    parameter int DRAIN_DEPTH = 3,
    parameter int CNT_W       = 32
) (
    input logic                clk,
    input logic                reset,
    hazard_stall_ctrl_if.master bus
);
    localparam int DW = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;

    typedef enum logic {M_IDLE, M_WAIT} mem_state_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;

    mem_state_t  mstate, mem_nxt;
    halt_state_t hstate, halt_nxt;
    logic [DW-1:0]    drain_cnt, drain_nxt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic mem_done, mem_stall, load_use;
    logic stall_inc, flush_inc;
    logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b;

    always_comb begin
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_f    = 1'b0;
        idex_w    = 1'b1;
        idex_b    = 1'b0;
        exmem_w   = 1'b1;
        memwb_b   = 1'b0;
        mem_nxt   = mstate;
        halt_nxt  = hstate;
        drain_nxt = drain_cnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        // Once a miss is outstanding the request has already been accepted.
        if (mstate == M_IDLE)
            mem_done = bus.dcache_ready & bus.dcache_valid & bus.dcache_hit;
        else
            mem_done = bus.dcache_valid & bus.dcache_hit;
        mem_stall = bus.exmem_mem_req & ~mem_done;

        load_use = bus.idex_mem_read && (bus.idex_rd != 5'd0) &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == bus.idex_rd)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == bus.idex_rd)));

        if (reset) begin
            mem_nxt = M_IDLE;
        end else if (hstate == HALTED) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
        end else begin
            unique case (mstate)
                M_IDLE:  if (mem_stall) mem_nxt = M_WAIT;
                M_WAIT:  if (mem_done)  mem_nxt = M_IDLE;
                default: mem_nxt = M_IDLE;
            endcase

            if (mem_stall) begin
                pc_w      = 1'b0;
                ifid_w    = 1'b0;
                idex_w    = 1'b0;
                exmem_w   = 1'b0;
                memwb_b   = 1'b1;
                stall_inc = 1'b1;
            end else if (hstate == DRAIN) begin
                pc_w      = 1'b0;
                ifid_w    = 1'b0;
                idex_b    = 1'b1;
                stall_inc = 1'b1;
                if (drain_cnt == DW'(DRAIN_DEPTH - 1))
                    halt_nxt = HALTED;
                else
                    drain_nxt = drain_cnt + 1'b1;
            end else if (bus.ex_mispredict) begin
                ifid_f    = 1'b1;
                idex_b    = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use) begin
                pc_w      = 1'b0;
                ifid_w    = 1'b0;
                idex_b    = 1'b1;
                stall_inc = 1'b1;
            end else if (bus.id_is_halt) begin
                idex_b    = 1'b1;
                halt_nxt  = DRAIN;
                drain_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstate    <= M_IDLE;
            hstate    <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            mstate    <= mem_nxt;
            hstate    <= halt_nxt;
            drain_cnt <= drain_nxt;
            stall_cnt <= stall_cnt + CNT_W'(stall_inc);
            flush_cnt <= flush_cnt + CNT_W'(flush_inc);
        end
    end

    assign bus.pc_write     = pc_w;
    assign bus.ifid_write   = ifid_w;
    assign bus.ifid_flush   = ifid_f;
    assign bus.idex_write   = idex_w;
    assign bus.idex_bubble  = idex_b;
    assign bus.exmem_write  = exmem_w;
    assign bus.memwb_bubble = memwb_b;
    assign bus.is_halted    = (hstate == HALTED);
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed control vectors.
module tb_hazard_stall_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    hazard_stall_ctrl_if #(.CNT_W(32)) bus ();

    hazard_stall_ctrl #(.DRAIN_DEPTH(3), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // ctl bits: pc_w ifid_w ifid_flush idex_w idex_bub exmem_w memwb_bub halted
    localparam logic [7:0] C_RUN   = 8'hD4;
    localparam logic [7:0] C_LU    = 8'h1C;
    localparam logic [7:0] C_MISS  = 8'h02;
    localparam logic [7:0] C_FLUSH = 8'hFC;
    localparam logic [7:0] C_HALT  = 8'hDC;
    localparam logic [7:0] C_DRAIN = 8'h1C;
    localparam logic [7:0] C_DONE  = 8'h01;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ctl();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.idex_write, bus.idex_bubble, bus.exmem_write,
                bus.memwb_bubble, bus.is_halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_rs1        = '0;
        bus.id_rs2        = '0;
        bus.id_use_rs1    = 1'b0;
        bus.id_use_rs2    = 1'b0;
        bus.id_is_halt    = 1'b0;
        bus.idex_rd       = '0;
        bus.idex_mem_read = 1'b0;
        bus.ex_mispredict = 1'b0;
        bus.exmem_mem_req = 1'b0;
        bus.dcache_ready  = 1'b0;
        bus.dcache_valid  = 1'b0;
        bus.dcache_hit    = 1'b0;
    endtask

    task automatic miss_in(input logic rdy, input logic vld, input logic hit);
        bus.exmem_mem_req = 1'b1;
        bus.dcache_ready  = rdy;
        bus.dcache_valid  = vld;
        bus.dcache_hit    = hit;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        clear_in();
        #12;
        check("rst_ctl", 32'(ctl()), 32'(C_RUN));
        check("rst_stall", bus.stall_cycles, 0);
        check("rst_flush", bus.flush_count, 0);
        tick();
        reset = 1'b0;

        // load-use on rs2
        bus.idex_mem_read = 1'b1;
        bus.idex_rd       = 5'd5;
        bus.id_rs2        = 5'd5;
        bus.id_use_rs2    = 1'b1;
        #1 check("lu_ctl", 32'(ctl()), 32'(C_LU));
        tick();
        check("lu_cnt", bus.stall_cycles, 1);
        bus.idex_rd = 5'd0;
        bus.id_rs2  = 5'd0;
        #1 check("lu_x0", 32'(ctl()), 32'(C_RUN));
        bus.idex_rd    = 5'd7;
        bus.id_rs1     = 5'd7;
        bus.id_use_rs2 = 1'b0;
        #1 check("lu_unused", 32'(ctl()), 32'(C_RUN));
        tick();
        check("lu_x0_cnt", bus.stall_cycles, 1);
        clear_in();

        // 4-cycle miss; ready dropping after acceptance proves M_WAIT
        miss_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("miss_%0d", i), 32'(ctl()), 32'(C_MISS));
            tick();
            bus.dcache_ready = 1'b0;
        end
        miss_in(1'b0, 1'b1, 1'b1);
        #1 check("miss_rel", 32'(ctl()), 32'(C_RUN));
        tick();
        clear_in();
        check("miss_cnt", bus.stall_cycles, 5);

        // same-cycle hit; then valid without ready must stall in M_IDLE
        miss_in(1'b1, 1'b1, 1'b1);
        #1 check("hit_ctl", 32'(ctl()), 32'(C_RUN));
        tick();
        check("hit_cnt", bus.stall_cycles, 5);
        miss_in(1'b0, 1'b1, 1'b1);
        #1 check("idle_noready", 32'(ctl()), 32'(C_MISS));
        tick();
        #1 check("wait_rel", 32'(ctl()), 32'(C_RUN));
        tick();
        clear_in();
        check("hit2_cnt", bus.stall_cycles, 6);

        // mispredict held across a 3-cycle miss
        bus.ex_mispredict = 1'b1;
        miss_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mp_miss_%0d", i), 32'(ctl()), 32'(C_MISS));
            tick();
        end
        check("mp_defer", bus.flush_count, 0);
        miss_in(1'b1, 1'b1, 1'b1);
        #1 check("mp_rel", 32'(ctl()), 32'(C_FLUSH));
        tick();
        clear_in();
        check("mp_flush", bus.flush_count, 1);
        check("mp_stall", bus.stall_cycles, 9);

        // halt with a 2-cycle miss inside the drain
        bus.id_is_halt = 1'b1;
        #1 check("halt_issue", 32'(ctl()), 32'(C_HALT));
        tick();
        clear_in();
        #1 check("drain_0", 32'(ctl()), 32'(C_DRAIN));
        tick();
        miss_in(1'b1, 1'b0, 1'b0);
        #1 check("drain_miss0", 32'(ctl()), 32'(C_MISS));
        tick();
        #1 check("drain_miss1", 32'(ctl()), 32'(C_MISS));
        tick();
        miss_in(1'b1, 1'b1, 1'b1);
        #1 check("drain_1", 32'(ctl()), 32'(C_DRAIN));
        tick();
        clear_in();
        #1 check("drain_2", 32'(ctl()), 32'(C_DRAIN));
        check("drain_not_halted", 32'(bus.is_halted), 0);
        tick();
        check("halted", 32'(ctl()), 32'(C_DONE));
        check("halt_stall", bus.stall_cycles, 14);

        // halted ignores everything
        bus.ex_mispredict = 1'b1;
        bus.idex_mem_read = 1'b1;
        bus.idex_rd       = 5'd3;
        bus.id_rs1        = 5'd3;
        bus.id_use_rs1    = 1'b1;
        miss_in(1'b1, 1'b0, 1'b0);
        #1 check("halted_ign", 32'(ctl()), 32'(C_DONE));
        tick();
        check("halted_stall", bus.stall_cycles, 14);
        check("halted_flush", bus.flush_count, 1);

        // reset out of HALTED
        reset = 1'b1;
        #1 check("rst_halt_ctl", 32'(ctl()), 32'(C_RUN));
        check("rst_halt_stall", bus.stall_cycles, 0);
        check("rst_halt_flush", bus.flush_count, 0);
        tick();
        reset = 1'b0;
        clear_in();

        // reset mid-drain while in M_WAIT, inputs still asserting a miss
        bus.id_is_halt = 1'b1;
        #1 check("halt2_issue", 32'(ctl()), 32'(C_HALT));
        tick();
        bus.id_is_halt = 1'b0;
        miss_in(1'b1, 1'b0, 1'b0);
        #1 check("halt2_miss", 32'(ctl()), 32'(C_MISS));
        tick();
        check("halt2_stall", bus.stall_cycles, 1);
        #2 reset = 1'b1;
        #1 check("rst_wait_ctl", 32'(ctl()), 32'(C_RUN));
        check("rst_wait_stall", bus.stall_cycles, 0);
        check("rst_wait_halt", 32'(bus.is_halted), 0);
        tick();
        reset = 1'b0;
        clear_in();
        #1 check("post_rst", 32'(ctl()), 32'(C_RUN));
        tick();
        check("post_rst_cnt", bus.stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central sequencing controller for the 5-stage pipelined RV32I core.
- Decides every cycle which pipeline registers advance, hold, or take a bubble, from three sources:
  - load-use hazards,
  - EX-stage branch/jump mispredicts,
  - data-cache miss handshakes.
- Also runs the ECALL halt sequence: drains in-flight instructions, then raises is_halted.
- Keeps stall and flush performance counters.

Parameters:
- DRAIN_DEPTH, 3, cycles to retire the instructions behind an ECALL (EX, MEM, WB) before halting.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- id_rs1  input  5  rs1 field of instruction in ID
- id_rs2  input  5  rs2 field of instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_is_halt  input  1  ID holds ECALL with forwarded x17==10
- idex_rd  input  5  rd of instruction in EX
- idex_mem_read  input  1  EX instruction is a load
- ex_mispredict  input  1  EX resolved a taken branch, JAL or JALR with wrong next PC
- exmem_mem_req  input  1  MEM instruction performs a load or store
- dcache_ready  input  1  cache accepts a request this cycle
- dcache_valid  input  1  cache output/ack valid
- dcache_hit  input  1  access hit
- pc_write  output  1  PC register updates
- ifid_write  output  1  IF/ID updates
- ifid_flush  output  1  IF/ID loads a NOP
- idex_write  output  1  ID/EX updates
- idex_bubble  output  1  ID/EX loads a NOP
- exmem_write  output  1  EX/MEM updates
- memwb_bubble  output  1  MEM/WB loads a NOP
- is_halted  output  1  core halted, sticky
- stall_cycles  output  CNT_W  cycles with any stall or drain
- flush_count  output  CNT_W  number of mispredict flushes

Behaviour:
- Reset (asynchronous): mem FSM = M_IDLE, halt FSM = RUN, drain counter = 0, is_halted = 0, both counters = 0.
- Outputs are combinational from state and inputs. Their reset-time values are:
  - pc_write = ifid_write = idex_write = exmem_write = 1
  - flushes and bubbles = 0
- Reset mid-miss or mid-drain returns to these values immediately.

Mem FSM {M_IDLE, M_WAIT}:
- mem_done = dcache_ready & dcache_valid & dcache_hit in M_IDLE; dcache_valid & dcache_hit in M_WAIT.
- mem_stall = exmem_mem_req & !mem_done.
- Transitions:
  - M_IDLE -> M_WAIT when mem_stall.
  - M_WAIT -> M_IDLE when mem_done.
  - Otherwise stay.
- While mem_stall:
  - pc_write, ifid_write, idex_write, exmem_write = 0.
  - memwb_bubble = 1.
  - All other flush/bubble = 0.
- On the mem_done cycle the stall drops; the pipeline advances that same cycle.

Priority (highest first) when mem_stall = 0:
- Mispredict: ifid_flush = 1, idex_bubble = 1, PC writes (redirect). flush_count += 1.
  - ex_mispredict during mem_stall is deferred, not lost: EX is held, so the input persists. It is counted once, when it takes effect.
- Load-use: idex_mem_read & idex_rd != 0, and either (id_use_rs1 & id_rs1 == idex_rd) or (id_use_rs2 & id_rs2 == idex_rd).
  - Response: pc_write = 0, ifid_write = 0, idex_bubble = 1.
- Halt: id_is_halt with neither of the above → halt FSM RUN -> DRAIN.
  - The ECALL itself enters EX as a bubble (idex_bubble = 1).
  - A halt squashed by a mispredict the same cycle is ignored.

Halt FSM {RUN, DRAIN, HALTED}:
- DRAIN:
  - pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - The counter increments only on cycles without mem_stall.
  - At count == DRAIN_DEPTH-1 (non-stall cycle) → HALTED.
- HALTED:
  - is_halted = 1.
  - All write enables = 0.
  - Ignores all inputs until reset.

Counters:
- stall_cycles += 1 on any cycle with mem_stall, load-use stall, or DRAIN.
- Counters wrap modulo 2^CNT_W.
- Counters are frozen in HALTED.

Test Plan:
- Load-use: idex_mem_read = 1, idex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 → one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_cycles = 1. Same with idex_rd = 0 → no stall.
- Miss: exmem_mem_req = 1, dcache_ready = 1, dcache_valid = 0 for 4 cycles, then valid & hit → 4 cycles with all writes = 0 and memwb_bubble = 1. FSM M_WAIT. Release on the 5th cycle; stall_cycles = 4.
- Hit: exmem_mem_req with ready, valid and hit in the same cycle → no stall; FSM stays M_IDLE.
- Mispredict during miss: ex_mispredict = 1 throughout a 3-cycle miss → no flush during the miss. ifid_flush and idex_bubble assert on the release cycle; flush_count = 1.
- Halt: id_is_halt = 1, no hazards → 3 DRAIN cycles, then is_halted = 1 and all writes = 0. A 2-cycle miss during DRAIN → is_halted is delayed by 2 cycles.
- Async reset asserted in M_WAIT/DRAIN → outputs return immediately to reset values, counters = 0, is_halted = 0.
